multicycle_rv_core: RTL and testbench

Parametrised multi-cycle successor to the single-cycle reduced RISC-V datapath. It contains the register file, ALU, immediate extender and PC internally, and sequences each instruction through a fetch/decode/execute/writeback FSM. Instruction fetch uses a ready/valid-style memory port, so wait-state ROM/SRAM models can be attached. It traps on unsupported encodings. It is the top-level compute block; a0 is exported for the existing display/test harness.

---
 rtl/multicycle_rv_core.sv | 169 ++++++++++++++++
 tb/tb_multicycle_rv_core.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_rv_core.sv
// multicycle_rv_core
// Multi-cycle reduced RISC-V core (ADD, SUB, ADDI, LUI, BEQ, BNE, JAL).
// Each instruction walks IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH.
// Unsupported encodings and misaligned control-flow targets park the core
// in TRAP until reset.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-low reset
//   imem_req     fetch request (high for every FETCH cycle)
//   imem_addr    fetch address (= PC)
//   imem_rvalid  instruction word valid
//   imem_rdata   instruction word
//   a0out        register x10
//   pc_out       current PC
//   retire       high in the WB cycle of each completed instruction
//   illegal      sticky trap flag
//   state_dbg    current FSM state encoding
//
// Fetch handshake: while in FETCH the core holds imem_req=1 and imem_addr=PC
// stable; the word is accepted on the rising edge where imem_req and
// imem_rvalid are both high. imem_rvalid is ignored whenever imem_req is low.
module multicycle_rv_core #(
  parameter int DW = 32,
  parameter int ADDR_W = 32,
  parameter int NREG = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [DW-1:0]     a0out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              illegal,
  output logic [2:0]        state_dbg
);
  localparam int RW = (NREG == 16) ? 4 : 5;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_TRAP
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] pc, npc_q;
  logic [31:0]       ir, imm_q;
  logic [DW-1:0]     regs [NREG];
  logic [DW-1:0]     op_a, op_b, alu_q;

  // Field decode works straight off IR, which is stable from DECODE to WB.
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [RW-1:0] rs1_idx, rs2_idx, rd_idx;
  logic is_add, is_sub, is_addi, is_lui, is_beq, is_bne, is_jal;
  logic uses_rs1, uses_rs2, uses_rd, legal;
  logic [31:0] imm32;

  assign opcode  = ir[6:0];
  assign f3      = ir[14:12];
  assign f7      = ir[31:25];
  assign rd_idx  = ir[7 +: RW];
  assign rs1_idx = ir[15 +: RW];
  assign rs2_idx = ir[20 +: RW];

  always_comb begin
    is_add  = (opcode == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000);
    is_sub  = (opcode == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0100000);
    is_addi = (opcode == 7'b0010011) && (f3 == 3'b000);
    is_lui  = (opcode == 7'b0110111);
    is_beq  = (opcode == 7'b1100011) && (f3 == 3'b000);
    is_bne  = (opcode == 7'b1100011) && (f3 == 3'b001);
    is_jal  = (opcode == 7'b1101111);
    uses_rs1 = is_add | is_sub | is_addi | is_beq | is_bne;
    uses_rs2 = is_add | is_sub | is_beq | is_bne;
    uses_rd  = is_add | is_sub | is_addi | is_lui | is_jal;
    legal = is_add | is_sub | is_addi | is_lui | is_beq | is_bne | is_jal;
    // A 16-entry file cannot name x16..x31 in any field the instruction uses.
    if (NREG == 16 && ((uses_rs1 && ir[19]) || (uses_rs2 && ir[24]) ||
                       (uses_rd && ir[11])))
      legal = 1'b0;
    imm32 = '0;
    if (is_addi) imm32 = {{20{ir[31]}}, ir[31:20]};
    if (is_lui)  imm32 = {ir[31:12], 12'b0};
    if (is_beq || is_bne)
      imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    if (is_jal)
      imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  end

  // Execute datapath, registered at the end of EXEC.
  logic [DW-1:0]     imm_dw, alu_res;
  logic [ADDR_W-1:0] pc_plus4, target, next_pc;
  logic              taken, misalign;

  always_comb begin
    imm_dw   = DW'($signed(imm_q));
    pc_plus4 = pc + ADDR_W'(4);
    target   = pc + ADDR_W'($signed(imm_q));
    taken    = is_jal | (is_beq && (op_a == op_b)) | (is_bne && (op_a != op_b));
    misalign = taken && (target[1:0] != 2'b00);
    next_pc  = taken ? target : pc_plus4;
    alu_res  = '0;
    if (is_add)  alu_res = op_a + op_b;
    if (is_sub)  alu_res = op_a - op_b;
    if (is_addi) alu_res = op_a + imm_dw;
    if (is_lui)  alu_res = imm_dw;
    if (is_jal)  alu_res = DW'(pc_plus4);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  if (imem_rvalid) state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
      S_EXEC:   state_next = misalign ? S_TRAP : S_WB;
      S_WB:     state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      ir      <= '0;
      imm_q   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      alu_q   <= '0;
      npc_q   <= '0;
      illegal <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_next;
      if (state_next == S_TRAP) illegal <= 1'b1;
      case (state)
        S_FETCH: if (imem_rvalid) ir <= imem_rdata;
        S_DECODE: begin
          op_a  <= regs[rs1_idx];
          op_b  <= regs[rs2_idx];
          imm_q <= imm32;
        end
        S_EXEC: begin
          alu_q <= alu_res;
          npc_q <= next_pc;
        end
        S_WB: begin
          // x0 is never written, so it reads back as zero.
          if (uses_rd && (rd_idx != '0)) regs[rd_idx] <= alu_q;
          pc <= npc_q;
        end
        default: ;
      endcase
    end
  end

  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign retire    = (state == S_WB);
  assign a0out     = regs[10];
  assign pc_out    = pc;
  assign state_dbg = state;
endmodule

// File: tb/tb_multicycle_rv_core.sv
module tb_multicycle_rv_core;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // main core (defaults: DW=32, ADDR_W=32, NREG=32, RESET_PC=0)
  logic        imem_req, imem_rvalid, retire, illegal;
  logic [31:0] imem_addr, imem_rdata, a0out, pc_out;
  logic [2:0]  state_dbg;

  // small core: NREG=16, RESET_PC=0x100
  logic        imem_req2, imem_rvalid2, retire2, illegal2;
  logic [31:0] imem_addr2, imem_rdata2, a0out2, pc_out2;
  logic [2:0]  state_dbg2;

  multicycle_rv_core dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .a0out(a0out),
    .pc_out(pc_out), .retire(retire), .illegal(illegal), .state_dbg(state_dbg)
  );

  multicycle_rv_core #(.NREG(16), .RESET_PC(32'h100)) dut16 (
    .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2), .a0out(a0out2),
    .pc_out(pc_out2), .retire(retire2), .illegal(illegal2),
    .state_dbg(state_dbg2)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] mem [0:63];
  int          wait_cycles = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];   // {pc_out, a0out} expected after each retire

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory responders ----------------
  // Main memory: wait_cycles idle cycles before each word; outside a request
  // it drives noisy rvalid with an illegal word, which the core must ignore.
  initial begin
    int wcnt;
    wcnt = 0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (wcnt >= wait_cycles) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem[imem_addr[7:2]];
          wcnt = 0;
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata = 32'hFFFF_FFFF;
          wcnt++;
        end
      end else begin
        imem_rvalid = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        wcnt = 0;
      end
    end
  end

  // Small core memory: 0x100 ADDI x10,x0,7 ; 0x104 ADD x16,x0,x0
  initial begin
    imem_rvalid2 = 1'b0;
    imem_rdata2 = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid2 = imem_req2;
      imem_rdata2 = (imem_addr2 == 32'h100) ? 32'h0050_0513 + 32'h0020_0000
                                            : 32'h0000_0833;
    end
  end

  // ---------------- monitor ----------------
  // One cycle after a retire pulse PC and a0 show the committed result.
  initial begin
    logic        pend;
    logic [63:0] e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL retire_unexpected: got pc %h a0 %h expected none",
                   pc_out, a0out);
        end else begin
          e = exp_q.pop_front();
          check("retire_pc", {32'h0, pc_out}, {32'h0, e[63:32]});
          check("retire_a0", {32'h0, a0out}, {32'h0, e[31:0]});
        end
      end
      if (retire) pend = 1'b1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
  endtask

  // Reset for two edges; returns at the negedge where rst is released
  // (core sits in IDLE there).
  task automatic start_core(input string name);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    check({name, "_rst_req"}, {63'h0, imem_req}, 64'h0);
    check({name, "_rst_retire"}, {63'h0, retire}, 64'h0);
    check({name, "_rst_illegal"}, {63'h0, illegal}, 64'h0);
    check({name, "_rst_pc"}, {32'h0, pc_out}, 64'h0);
    check({name, "_rst_a0"}, {32'h0, a0out}, 64'h0);
  endtask

  task automatic wait_trap(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (illegal) break;
    end
    check({name, "_trap"}, {63'h0, illegal}, 64'h1);
    check({name, "_q_empty"}, 64'(exp_q.size()), 64'h0);
  endtask

  // Measures fetch behaviour of the first instruction. lat counts cycles
  // with the FETCH-entry cycle as 1.
  task automatic fetch_timing(input string name, input int w, input int lat_exp);
    int lat, req_cycles;
    logic addr_ok;
    start_core(name);
    @(negedge clk);
    check({name, "_req_rise"}, {63'h0, imem_req}, 64'h1);
    lat = 1;
    req_cycles = 0;
    addr_ok = 1'b1;
    while (lat < 30) begin
      if (imem_req) begin
        req_cycles++;
        if (imem_addr != 32'h0) addr_ok = 1'b0;
      end
      if (retire) break;
      @(negedge clk);
      lat++;
    end
    check({name, "_retire_lat"}, 64'(lat), 64'(lat_exp));
    check({name, "_req_cycles"}, 64'(req_cycles), 64'(w + 1));
    check({name, "_addr_stable"}, {63'h0, addr_ok}, 64'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, r2;
    logic bad;
    clear_mem();

    // T1: ADDI x10,x0,5 with zero-wait memory
    mem[0] = 32'h0050_0513;
    wait_cycles = 0;
    exp_q.push_back({32'h4, 32'h5});
    fetch_timing("t1", 0, 4);
    wait_trap("t1", 40);

    // T2: same, three wait cycles
    wait_cycles = 3;
    exp_q.push_back({32'h4, 32'h5});
    fetch_timing("t2", 3, 7);
    wait_trap("t2", 40);

    // T3: countdown loop, one wait cycle per fetch
    clear_mem();
    mem[0] = 32'h0030_0513;  // ADDI a0,x0,3
    mem[1] = 32'hFFF5_0513;  // ADDI a0,a0,-1
    mem[2] = 32'hFE05_1EE3;  // BNE a0,x0,-4
    wait_cycles = 1;
    exp_q.push_back({32'h4, 32'h3});
    exp_q.push_back({32'h8, 32'h2});
    exp_q.push_back({32'h4, 32'h2});
    exp_q.push_back({32'h8, 32'h1});
    exp_q.push_back({32'h4, 32'h1});
    exp_q.push_back({32'h8, 32'h0});
    exp_q.push_back({32'hC, 32'h0});
    start_core("t3");
    wait_trap("t3", 300);
    check("t3_final_pc", {32'h0, pc_out}, 64'hC);

    // T4: overflow wrap, SUB, x0 discard, JAL link, BEQ taken
    clear_mem();
    mem[0]  = 32'hFFF0_0093;  // ADDI x1,x0,-1
    mem[1]  = 32'h8000_0137;  // LUI  x2,0x80000
    mem[2]  = 32'hFFF1_0113;  // ADDI x2,x2,-1   -> 0x7FFFFFFF
    mem[3]  = 32'h4010_01B3;  // SUB  x3,x0,x1   -> 1
    mem[4]  = 32'h0080_00EF;  // JAL  x1,8 (PC 0x10)
    mem[5]  = 32'h0630_0513;  // ADDI x10,x0,99 (skipped)
    mem[6]  = 32'h0031_0533;  // ADD  x10,x2,x3  -> 0x80000000
    mem[7]  = 32'h4015_0533;  // SUB  x10,x10,x1 -> 0x7FFFFFEC
    mem[8]  = 32'h0000_8533;  // ADD  x10,x1,x0  -> 0x14
    mem[9]  = 32'h0070_0013;  // ADDI x0,x0,7
    mem[10] = 32'h0000_0533;  // ADD  x10,x0,x0  -> 0
    mem[11] = 32'h0000_0463;  // BEQ  x0,x0,8
    mem[12] = 32'h0630_0513;  // ADDI x10,x0,99 (skipped)
    mem[13] = 32'h8000_0513;  // ADDI x10,x0,-2048
    wait_cycles = 0;
    exp_q.push_back({32'h04, 32'h0});
    exp_q.push_back({32'h08, 32'h0});
    exp_q.push_back({32'h0C, 32'h0});
    exp_q.push_back({32'h10, 32'h0});
    exp_q.push_back({32'h18, 32'h0});
    exp_q.push_back({32'h1C, 32'h8000_0000});
    exp_q.push_back({32'h20, 32'h7FFF_FFEC});
    exp_q.push_back({32'h24, 32'h14});
    exp_q.push_back({32'h28, 32'h14});
    exp_q.push_back({32'h2C, 32'h0});
    exp_q.push_back({32'h34, 32'h0});
    exp_q.push_back({32'h38, 32'hFFFF_F800});
    start_core("t4");
    wait_trap("t4", 300);
    check("t4_trap_pc", {32'h0, pc_out}, 64'h38);

    // T5a: misaligned JAL target traps without retiring
    clear_mem();
    mem[0] = 32'h0050_0513;  // ADDI x10,x0,5
    mem[1] = 32'h0020_00EF;  // JAL x1,2 -> target 6
    exp_q.push_back({32'h4, 32'h5});
    start_core("t5a");
    wait_trap("t5a", 60);
    check("t5a_pc", {32'h0, pc_out}, 64'h4);
    check("t5a_a0", {32'h0, a0out}, 64'h5);

    // T5b: all-zero word is illegal; trap visible the cycle after DECODE
    mem[1] = 32'h0;
    exp_q.push_back({32'h4, 32'h5});
    start_core("t5b");
    for (int c = 1; c <= 6; c++) @(negedge clk);  // cycle 6 = DECODE
    check("t5b_decode_illegal", {63'h0, illegal}, 64'h0);
    @(negedge clk);
    check("t5b_trap_illegal", {63'h0, illegal}, 64'h1);
    check("t5b_trap_req", {63'h0, imem_req}, 64'h0);
    r = 0;
    bad = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (retire) r++;
      if (imem_req) bad = 1'b1;
    end
    check("t5b_no_retire", 64'(r), 64'h0);
    check("t5b_no_req", {63'h0, bad}, 64'h0);
    check("t5b_pc_frozen", {32'h0, pc_out}, 64'h4);
    check("t5b_sticky", {63'h0, illegal}, 64'h1);
    rst = 1'b0;
    @(negedge clk);
    check("t5b_rst_illegal", {63'h0, illegal}, 64'h0);
    check("t5b_rst_pc", {32'h0, pc_out}, 64'h0);

    // T6a: reset while FETCH waits on rvalid
    clear_mem();
    mem[0] = 32'h0050_0513;  // ADDI x10,x0,5
    mem[1] = 32'h0015_0513;  // ADDI x10,x10,1
    wait_cycles = 5;
    exp_q.push_back({32'h4, 32'h5});
    start_core("t6a");
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (retire) break;
    end
    check("t6a_first_retire", {63'h0, retire}, 64'h1);
    repeat (3) @(negedge clk);
    check("t6a_waiting_req", {63'h0, imem_req}, 64'h1);
    check("t6a_waiting_addr", {32'h0, imem_addr}, 64'h4);
    rst = 1'b0;
    @(negedge clk);
    check("t6a_rst_req", {63'h0, imem_req}, 64'h0);
    check("t6a_rst_pc", {32'h0, pc_out}, 64'h0);
    check("t6a_rst_a0", {32'h0, a0out}, 64'h0);
    exp_q.push_back({32'h4, 32'h5});
    exp_q.push_back({32'h8, 32'h6});
    rst = 1'b1;
    @(negedge clk);
    check("t6a_refetch_req", {63'h0, imem_req}, 64'h1);
    check("t6a_refetch_addr", {32'h0, imem_addr}, 64'h0);
    wait_trap("t6a", 200);
    check("t6a_final_a0", {32'h0, a0out}, 64'h6);

    // T6b: NREG=16 core, RESET_PC=0x100; ADD x16,x0,x0 must trap
    clear_mem();
    wait_cycles = 0;
    start_core("t6b");
    check("t6b_rst_pc", {32'h0, pc_out2}, 64'h100);
    r2 = 0;
    bad = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (retire2) r2++;
      if (imem_req2 && imem_addr2 != 32'h100 && imem_addr2 != 32'h104)
        bad = 1'b1;
    end
    check("t6b_retires", 64'(r2), 64'h1);
    check("t6b_addr", {63'h0, bad}, 64'h0);
    check("t6b_a0", {32'h0, a0out2}, 64'h7);
    check("t6b_pc", {32'h0, pc_out2}, 64'h104);
    check("t6b_illegal", {63'h0, illegal2}, 64'h1);
    check("t6b_req", {63'h0, imem_req2}, 64'h0);
    check("main_q_empty", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
